// File: rtl/vdec_hs_crc_chk.sv
// ---------------------------------------------------------------------------
// vdec_hs_crc_chk
// CRC checker for the HS decoder output path. It accumulates a CRC over a
// block of info bits, DIN_W bits per clock, then captures the appended
// received CRC bits. It compares the two and reports pass/fail together
// with a one-cycle done strobe.
//
// Optional feature macro: VDEC_HS_CRC_MASK_EN
//   When it is defined, the module gains an input ue_mask. The mask is
//   latched at start and XORed into the compare, to support UE-ID-masked
//   CRCs. crc_val itself stays unmasked.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   start    in   one-cycle pulse; latches blk_len and opens a new block
//   blk_len  in   info bits in the block (CRC bits not included)
//   din_vld  in   din carries a valid word this cycle
//   din      in   data word; din[DIN_W-1] is the earliest bit in time
//   ue_mask  in   (macro only) CRC mask, sampled at start
//   busy     out  a block is in progress (DATA, CHK or DONE)
//   crc_done out  one-cycle pulse when the check completes
//   crc_ok   out  check result; valid with crc_done, held until next start
//   crc_val  out  CRC computed over the info bits
//   rx_crc   out  received CRC bits; the first received bit is the MSB
// ---------------------------------------------------------------------------
module vdec_hs_crc_chk #(
  parameter int                CRC_W    = 16,
  parameter logic [CRC_W-1:0]  POLY     = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0]  CRC_INIT = '0,
  parameter int                DIN_W    = 1,
  parameter int                LEN_W    = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   blk_len,
  input  logic               din_vld,
  input  logic [DIN_W-1:0]   din,
`ifdef VDEC_HS_CRC_MASK_EN
  input  logic [CRC_W-1:0]   ue_mask,
`endif
  output logic               busy,
  output logic               crc_done,
  output logic               crc_ok,
  output logic [CRC_W-1:0]   crc_val,
  output logic [CRC_W-1:0]   rx_crc
);

  localparam int CNT_W = $clog2(CRC_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, CHK, DONE} state_t;

  state_t             state, state_nxt;
  logic [CRC_W-1:0]   lfsr;
  logic [CRC_W-1:0]   rx_sr;
  logic [CRC_W-1:0]   mask_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   bit_cnt_inc;
  logic [CNT_W-1:0]   crc_cnt;
  logic [CNT_W-1:0]   crc_cnt_inc;
  logic               ok_q;
  logic               cmp;

  // The serial recurrence is unrolled DIN_W times, starting with the MSB of w,
  // because the MSB is the earliest bit in time.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DIN_W-1:0] w);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DIN_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ w[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  assign bit_cnt_inc = bit_cnt + LEN_W'(DIN_W);
  assign crc_cnt_inc = crc_cnt + CNT_W'(DIN_W);
  assign cmp         = (rx_sr == (lfsr ^ mask_q));
  assign crc_val     = lfsr;
  assign rx_crc      = rx_sr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. start has priority in every state, so it aborts any
  // block that is in progress.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (blk_len == '0) ? CHK : DATA;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        DATA:    if (din_vld && bit_cnt_inc == len_q)             state_nxt = CHK;
        CHK:     if (din_vld && crc_cnt_inc == CNT_W'(CRC_W))     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs. crc_ok takes the live compare during DONE and the held copy
  // afterwards.
  always_comb begin
    busy     = (state != IDLE);
    crc_done = (state == DONE);
    crc_ok   = (state == DONE) ? cmp : ok_q;
  end

  // Block datapath: LFSR, received-CRC shifter, counters and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= '0;
      rx_sr   <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      crc_cnt <= '0;
      ok_q    <= 1'b0;
    end else if (start) begin
      lfsr    <= CRC_INIT;
      rx_sr   <= '0;
      len_q   <= blk_len;
      bit_cnt <= '0;
      crc_cnt <= '0;
      ok_q    <= 1'b0;
    end else begin
      case (state)
        DATA: if (din_vld) begin
          lfsr    <= crc_step(lfsr, din);
          bit_cnt <= bit_cnt_inc;
        end
        CHK: if (din_vld) begin
          rx_sr   <= (rx_sr << DIN_W) | CRC_W'(din);
          crc_cnt <= crc_cnt_inc;
        end
        DONE:    ok_q <= cmp;
        default: ;
      endcase
    end
  end

`ifdef VDEC_HS_CRC_MASK_EN
  always_ff @(posedge clk) begin
    if (rst)        mask_q <= '0;
    else if (start) mask_q <= ue_mask;
  end
`else
  assign mask_q = '0;
`endif

endmodule

// File: tb/tb_vdec_hs_crc_chk.sv
module tb_vdec_hs_crc_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // Serial instance (DIN_W = 1)
  logic        s1, v1;
  logic [12:0] len1;
  logic [0:0]  d1;
  logic        busy1, done1, ok1;
  logic [15:0] cv1, rx1;

  // Byte instance (DIN_W = 8)
  logic        s8, v8;
  logic [12:0] len8;
  logic [7:0]  d8;
  logic        busy8, done8, ok8;
  logic [15:0] cv8, rx8;

`ifdef VDEC_HS_CRC_MASK_EN
  logic [15:0] m1, m8;
`endif

  vdec_hs_crc_chk #(.CRC_W(16), .POLY(16'h1021), .CRC_INIT(16'h0000), .DIN_W(1), .LEN_W(13)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .blk_len(len1), .din_vld(v1), .din(d1),
`ifdef VDEC_HS_CRC_MASK_EN
    .ue_mask(m1),
`endif
    .busy(busy1), .crc_done(done1), .crc_ok(ok1), .crc_val(cv1), .rx_crc(rx1)
  );

  vdec_hs_crc_chk #(.CRC_W(16), .POLY(16'h1021), .CRC_INIT(16'h0000), .DIN_W(8), .LEN_W(13)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .blk_len(len8), .din_vld(v8), .din(d8),
`ifdef VDEC_HS_CRC_MASK_EN
    .ue_mask(m8),
`endif
    .busy(busy8), .crc_done(done8), .crc_ok(ok8), .crc_val(cv8), .rx_crc(rx8)
  );

  typedef struct {
    logic [15:0] cv;
    logic [15:0] rx;
    logic        ok;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done1_cnt = 0;
  int done8_cnt = 0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  always @(negedge clk) begin
    if (done1 === 1'b1) done1_cnt++;
    if (done8 === 1'b1) done8_cnt++;
  end

  // ---------------- stimulus primitives (inputs change #1 after posedge) ----
  task automatic start1(input logic [12:0] len);
    @(posedge clk); #1;
    s1 = 1'b1; len1 = len;
    @(posedge clk); #1;
    s1 = 1'b0;
  endtask

  task automatic start8(input logic [12:0] len);
    @(posedge clk); #1;
    s8 = 1'b1; len8 = len;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  task automatic word1(input logic b);
    v1 = 1'b1; d1 = b;
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic word8(input logic [7:0] b);
    v8 = 1'b1; d8 = b;
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_msg1();
    for (int i = 0; i < 9; i++)
      for (int b = 7; b >= 0; b--) word1(msg[i][b]);
  endtask

  task automatic send_crc1(input logic [15:0] c, input int nbits);
    for (int b = 15; b > 15 - nbits; b--) word1(c[b]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    s1 = 0; v1 = 0; len1 = '0; d1 = '0;
    s8 = 0; v8 = 0; len8 = '0; d8 = '0;
`ifdef VDEC_HS_CRC_MASK_EN
    m1 = '0; m8 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy1, done1, ok1, cv1, rx1} !== 35'd0)
      $display("FAIL reset_outputs_serial: got busy=%b done=%b ok=%b crc=%h rx=%h want all 0", busy1, done1, ok1, cv1, rx1);
    else pass_cnt++;
    total_cnt++;
    if ({busy8, done8, ok8, cv8, rx8} !== 35'd0)
      $display("FAIL reset_outputs_byte: got busy=%b done=%b ok=%b crc=%h rx=%h want all 0", busy8, done8, ok8, cv8, rx8);
    else pass_cnt++;
    rst = 1'b0;
    e.cv = '0;
  endtask

  task automatic test_serial();
    exp_t e;
    start1(13'd72);
    total_cnt++;
    if (busy1 !== 1'b1) $display("FAIL serial_busy: got %b want 1", busy1);
    else pass_cnt++;
    q1.push_back('{cv: 16'h31C3, rx: 16'h31C3, ok: 1'b1});
    send_msg1();
    send_crc1(16'h31C3, 16);
    total_cnt++;
    if (done1 !== 1'b1) $display("FAIL serial_done_latency: got %b want 1", done1);
    else pass_cnt++;
    if (done1 === 1'b1 && q1.size() > 0) begin
      e = q1.pop_front();
      total_cnt++;
      if (cv1 !== e.cv) $display("FAIL serial_crc_val: got %h want %h", cv1, e.cv);
      else pass_cnt++;
      total_cnt++;
      if (rx1 !== e.rx) $display("FAIL serial_rx_crc: got %h want %h", rx1, e.rx);
      else pass_cnt++;
      total_cnt++;
      if (ok1 !== e.ok) $display("FAIL serial_crc_ok: got %b want %b", ok1, e.ok);
      else pass_cnt++;
    end
    idle_cycles(1);
    total_cnt++;
    if (done1 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL serial_done_pulse: got done=%b busy=%b want 0 0", done1, busy1);
    else pass_cnt++;
    total_cnt++;
    if (ok1 !== 1'b1 || cv1 !== 16'h31C3) $display("FAIL serial_hold: got ok=%b crc=%h want 1 31c3", ok1, cv1);
    else pass_cnt++;
  endtask

  task automatic run_byte_block(input string name, input logic [15:0] rxc, input logic exp_ok);
    exp_t e;
    start8(13'd72);
    q8.push_back('{cv: 16'h31C3, rx: rxc, ok: exp_ok});
    for (int i = 0; i < 9; i++) word8(msg[i]);
    word8(rxc[15:8]);
    word8(rxc[7:0]);
    total_cnt++;
    if (done8 !== 1'b1) $display("FAIL %s_done: got %b want 1", name, done8);
    else pass_cnt++;
    if (done8 === 1'b1 && q8.size() > 0) begin
      e = q8.pop_front();
      total_cnt++;
      if (cv8 !== e.cv || rx8 !== e.rx || ok8 !== e.ok)
        $display("FAIL %s_result: got crc=%h rx=%h ok=%b want crc=%h rx=%h ok=%b", name, cv8, rx8, ok8, e.cv, e.rx, e.ok);
      else pass_cnt++;
    end
    idle_cycles(1);
  endtask

  task automatic test_byte_err();
    run_byte_block("byte_good", 16'h31C3, 1'b1);
    run_byte_block("byte_biterr", 16'h31C2, 1'b0);
  endtask

  task automatic test_gaps_abort();
    exp_t e;
    int   dc;
    start8(13'd72);
    total_cnt++;
    if (ok8 !== 1'b0 || cv8 !== 16'h0000) $display("FAIL start_clears: got ok=%b crc=%h want 0 0000", ok8, cv8);
    else pass_cnt++;
    q8.push_back('{cv: 16'h31C3, rx: 16'h31C3, ok: 1'b1});
    for (int i = 0; i < 5; i++) word8(msg[i]);
    idle_cycles(3);
    for (int i = 5; i < 9; i++) word8(msg[i]);
    word8(8'h31);
    idle_cycles(2);
    word8(8'hC3);
    total_cnt++;
    if (done8 !== 1'b1) $display("FAIL gaps_done: got %b want 1", done8);
    else pass_cnt++;
    if (done8 === 1'b1 && q8.size() > 0) begin
      e = q8.pop_front();
      total_cnt++;
      if (cv8 !== e.cv || rx8 !== e.rx || ok8 !== e.ok)
        $display("FAIL gaps_result: got crc=%h rx=%h ok=%b want crc=%h rx=%h ok=%b", cv8, rx8, ok8, e.cv, e.rx, e.ok);
      else pass_cnt++;
    end
    idle_cycles(1);
    // abort after four words, then a fresh full block
    dc = done8_cnt;
    start8(13'd72);
    for (int i = 0; i < 4; i++) word8(msg[i]);
    run_byte_block("after_abort", 16'h31C3, 1'b1);
    total_cnt++;
    if (done8_cnt - dc !== 1) $display("FAIL abort_no_done: got %0d done pulses want 1", done8_cnt - dc);
    else pass_cnt++;
  endtask

  task automatic test_empty();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      start8(13'd0);
      q8.push_back('{cv: 16'h0000, rx: (k == 0) ? 16'h0000 : 16'h0001, ok: (k == 0)});
      word8(8'h00);
      word8((k == 0) ? 8'h00 : 8'h01);
      total_cnt++;
      if (done8 !== 1'b1) $display("FAIL empty_done_%0d: got %b want 1", k, done8);
      else pass_cnt++;
      if (done8 === 1'b1 && q8.size() > 0) begin
        e = q8.pop_front();
        total_cnt++;
        if (cv8 !== e.cv || rx8 !== e.rx || ok8 !== e.ok)
          $display("FAIL empty_result_%0d: got crc=%h rx=%h ok=%b want crc=%h rx=%h ok=%b", k, cv8, rx8, ok8, e.cv, e.rx, e.ok);
        else pass_cnt++;
      end
      idle_cycles(1);
    end
  endtask

`ifdef VDEC_HS_CRC_MASK_EN
  task automatic test_mask();
    m8 = 16'h00FF;
    run_byte_block("mask_match", 16'h313C, 1'b1);
    run_byte_block("mask_unmasked", 16'h31C3, 1'b0);
    m8 = 16'h0000;
  endtask
`endif

  task automatic test_rst_midblock();
    int dc;
    start1(13'd72);
    send_msg1();
    send_crc1(16'h31C3, 5);
    total_cnt++;
    if (busy1 !== 1'b1) $display("FAIL midblock_busy: got %b want 1", busy1);
    else pass_cnt++;
    dc = done1_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy1, done1, ok1, cv1, rx1} !== 35'd0)
      $display("FAIL midblock_reset: got busy=%b done=%b ok=%b crc=%h rx=%h want all 0", busy1, done1, ok1, cv1, rx1);
    else pass_cnt++;
    // reset wins over start
    s1 = 1'b1; len1 = 13'd72;
    @(posedge clk); #1;
    s1 = 1'b0; rst = 1'b0;
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL rst_over_start: got busy=%b want 0", busy1);
    else pass_cnt++;
    idle_cycles(3);
    total_cnt++;
    if (done1_cnt !== dc) $display("FAIL midblock_no_done: got %0d pulses want %0d", done1_cnt, dc);
    else pass_cnt++;
    test_serial();
  endtask

  initial begin
    test_reset();
    test_serial();
    test_byte_err();
    test_gaps_abort();
    test_empty();
`ifdef VDEC_HS_CRC_MASK_EN
    test_mask();
`endif
    test_rst_midblock();
    total_cnt++;
    if (q1.size() != 0 || q8.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0/0", q1.size(), q8.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vdec_hs_crc_chk.md
Name: vdec_hs_crc_chk

Overview:
- Parametrised, multi-bit-per-cycle CRC checker for the HS decoder output path.
- Accumulates the CRC over a block of decoded info bits and captures the appended received CRC bits.
- Compares the two and reports pass/fail with a one-cycle done strobe.
- Generalises the serial CRC16 next-state function to any CRC width or polynomial and DIN_W bits per clock, and adds block framing, length counting and the compare.

Parameters:
- CRC_W, 16, CRC width in bits (8..32).
- POLY, 16'h1021, generator polynomial without the x^CRC_W term; bit k set means an x^k tap.
- CRC_INIT, 0, LFSR value loaded at block start.
- DIN_W, 1, bits per input word; legal values 1, 2, 4, 8; CRC_W must be a multiple of DIN_W.
- LEN_W, 13, width of the block-length field.

Ports:
- clk  in  1  system clock (307.2 MHz).
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; latches blk_len and initialises the block.
- blk_len  in  LEN_W  number of info bits, excluding CRC bits; must be a multiple of DIN_W.
- din_vld  in  1  din holds a valid word this cycle.
- din  in  DIN_W  data word; din[DIN_W-1] is the earliest bit in time.
- busy  out  1  high from the cycle after start until the done cycle.
- crc_done  out  1  one-cycle pulse, block check complete.
- crc_ok  out  1  check result; valid while crc_done is high, held until the next start.
- crc_val  out  CRC_W  computed CRC of the info bits; held until the next start.
- rx_crc  out  CRC_W  received CRC bits, first received bit at the MSB; held until the next start.

Behaviour:
- Reset: clk and rst only; one clock; reset is synchronous and active-high. While rst is high every output is 0, the state is IDLE and the counters are 0. rst wins over start.
- LFSR step, per bit b, matching the serial CRC16 recurrence:
  - fb = crc[CRC_W-1] ^ b
  - crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0)
  - Applied DIN_W times combinationally per accepted word, din[DIN_W-1] first.
- States:
  - IDLE: wait for start.
  - DATA: each din_vld word steps the LFSR; bit_cnt += DIN_W. Exit to CHK on the word where bit_cnt reaches blk_len.
  - CHK: each din_vld word shifts into rx_sr, MSB-first; crc_cnt += DIN_W. Exit to DONE on the word where crc_cnt reaches CRC_W.
  - DONE: one cycle. crc_done = 1, crc_ok = (rx_crc == crc_val ^ MASK), then go to IDLE.
- start handling:
  - On start the block loads LFSR = CRC_INIT, clears rx_sr and both counters, latches blk_len and clears crc_ok.
  - Next state is DATA, or CHK if blk_len == 0.
  - din_vld in the start cycle is ignored.
- Gaps: din_vld low means no state change (gaps allowed anywhere).
- Latency: crc_done is asserted in the cycle after the last CRC word is accepted.
- Abort: start while busy (DATA, CHK or DONE) discards the current block and re-initialises; no crc_done is issued for the aborted block.
- din_vld while IDLE is ignored.
- rst mid-block returns the block to IDLE with outputs 0 and no crc_done.
- Counters compare with ==. A blk_len that is not a multiple of DIN_W is illegal; behaviour is then undefined but must not lock up, and the next start recovers.

Optional Feature:
- Macro: VDEC_HS_CRC_MASK_EN.
- When defined:
  - Adds input port ue_mask (CRC_W), sampled at start and held for the block.
  - Compare becomes rx_crc == crc_val ^ ue_mask_latched. This supports UE-ID-masked CRC.
  - crc_val stays unmasked.
- When undefined: no port; MASK = 0.

Test Plan:
1. Serial path: DIN_W=1, POLY=16'h1021, CRC_INIT=0, blk_len=72. Send ASCII "123456789", each byte MSB first, then the 16 bits of 16'h31C3 → crc_val=16'h31C3, rx_crc=16'h31C3, crc_ok=1, crc_done exactly one cycle after the last bit.
2. Byte path, bit error: DIN_W=8, same data and CRC, with one CRC bit flipped (received 16'h31C2) → crc_val=16'h31C3, crc_ok=0, crc_done=1.
3. Gaps and abort: DIN_W=8. Drop din_vld for 3 cycles mid-block → same result as test 1. Then assert start after 4 data words → no crc_done. A fresh 9-byte block plus CRC afterwards → crc_ok=1.
4. Empty block: blk_len=0, CRC_INIT=0, received 16'h0000 → crc_val=0, crc_ok=1. With received 16'h0001 → crc_ok=0.
5. Mask (VDEC_HS_CRC_MASK_EN): ue_mask=16'h00FF, "123456789", received 16'h313C → crc_ok=1. Received 16'h31C3 → crc_ok=0.
6. Reset: assert rst while in CHK → all outputs 0 next cycle, no crc_done. A following block behaves as in test 1.
